// File: rtl/shape_scan.sv
// shape_scan: walks the shape table from slot 0 to count-1. Each slot is read through
// the shape record reader (shape_read). Empty slots (ty == 0) are skipped. Every
// non-empty record is presented downstream on a valid/ready handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, count          scan request pulse and number of slots (latched on start)
//   rd_id, rd_trigger     slot id and one-cycle trigger to the reader
//   rd_busy, rd_*         reader status and record fields
//   out_valid, out_ready  downstream handshake
//   out_id, out_*         captured record, out_last flags slot count-1
//   busy, done            scan in progress, one-cycle completion pulse
module shape_scan #(
    parameter int CORDW = 9,
    parameter int DATAW = 12,
    parameter int NUMW  = DATAW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUMW-1:0]  count,
    output logic [NUMW-1:0]  rd_id,
    output logic             rd_trigger,
    input  logic             rd_busy,
    input  logic [DATAW-1:0] rd_ty,
    input  logic [DATAW-1:0] rd_size,
    input  logic [DATAW-1:0] rd_rotate,
    input  logic [CORDW-1:0] rd_x,
    input  logic [CORDW-1:0] rd_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUMW-1:0]  out_id,
    output logic [DATAW-1:0] out_ty,
    output logic [DATAW-1:0] out_size,
    output logic [DATAW-1:0] out_rotate,
    output logic [CORDW-1:0] out_x,
    output logic [CORDW-1:0] out_y,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {StIdle, StIssue, StArm, StWait, StEmit} state_t;

    state_t          state;
    logic [NUMW-1:0] cur_id;
    logic [NUMW-1:0] count_q;
    logic [NUMW-1:0] last_id;
    logic            is_last;

    assign last_id = count_q - NUMW'(1);
    assign is_last = (cur_id == last_id);
    assign rd_id   = cur_id;
    assign busy    = (state != StIdle);

    // Advancing goes straight to StIssue (trigger raised on the same edge), so an
    // empty slot costs exactly 10 cycles with an 8-cycle reader.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            cur_id     <= '0;
            count_q    <= '0;
            rd_trigger <= 1'b0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_ty     <= '0;
            out_size   <= '0;
            out_rotate <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_trigger <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (count != '0) begin
                            count_q    <= count;
                            cur_id     <= '0;
                            rd_trigger <= 1'b1;
                            state      <= StIssue;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                StIssue: state <= StArm;
                // Reader raises busy only the cycle after trigger; ignore it here.
                StArm: state <= StWait;
                StWait: begin
                    if (!rd_busy) begin
                        out_id     <= cur_id;
                        out_ty     <= rd_ty;
                        out_size   <= rd_size;
                        out_rotate <= rd_rotate;
                        out_x      <= rd_x;
                        out_y      <= rd_y;
                        out_last   <= is_last;
                        if (rd_ty != '0) begin
                            out_valid <= 1'b1;
                            state     <= StEmit;
                        end else if (is_last) begin
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            cur_id     <= cur_id + NUMW'(1);
                            rd_trigger <= 1'b1;
                            state      <= StIssue;
                        end
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (is_last) begin
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            cur_id     <= cur_id + NUMW'(1);
                            rd_trigger <= 1'b1;
                            state      <= StIssue;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/shape_scan.md
Name: shape_scan

Overview:
- Sequencer that walks the shape table, slot id 0 to count-1.
- For each slot it triggers the shape record reader (shape_read) and waits until the reader finishes.
- It skips empty slots (ty == 0) and presents each non-empty record downstream, toward the rasteriser, on a valid/ready handshake.
- It sits directly downstream of shape_read and drives that block's id and trigger inputs.

Parameters:
- CORDW, 9, coordinate width (x, y).
- DATAW, 12, record word width (ty, size, rotate).
- NUMW, DATAW, slot id / count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse; begins a scan when idle.
- count  in  NUMW  number of slots to scan; latched on accepted start.
- rd_id  out  NUMW  slot id to reader; registered, stable for the whole read.
- rd_trigger  out  1  one-cycle pulse to the reader.
- rd_busy  in  1  reader busy.
- rd_ty  in  DATAW  reader output field.
- rd_size  in  DATAW  reader output field.
- rd_rotate  in  DATAW  reader output field.
- rd_x  in  CORDW  reader output field.
- rd_y  in  CORDW  reader output field.
- out_valid  out  1  record available.
- out_ready  in  1  downstream accepts.
- out_id  out  NUMW  slot id of the presented record.
- out_ty  out  DATAW  captured field.
- out_size  out  DATAW  captured field.
- out_rotate  out  DATAW  captured field.
- out_x  out  CORDW  captured field.
- out_y  out  CORDW  captured field.
- out_last  out  1  presented record is from slot count-1.
- busy  out  1  scan in progress (state != IDLE).
- done  out  1  one-cycle pulse when the scan completes.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including rd_id, rd_trigger, out_* fields, out_valid, out_last, busy, done. Internal cur_id and count_q are 0.
- Reset mid-scan: the scan aborts at once and no done pulse is issued. The reader is reset on the same rst, so no handshake is left dangling.
- IDLE:
  - start && count != 0: latch count_q <= count, cur_id <= 0, go to ISSUE.
  - start && count == 0: pulse done the next cycle and stay IDLE.
  - start while not IDLE is ignored.
- ISSUE: rd_trigger = 1 for exactly this cycle; rd_id = cur_id; go to ARM.
- ARM: one guard cycle, because the reader raises busy only the cycle after trigger. rd_busy is ignored here; go to WAIT.
- WAIT: hold until rd_busy == 0. On that cycle:
  - Capture rd_* into the out_* registers, out_id <= cur_id, out_last <= (cur_id == count_q-1).
  - If rd_ty == 0 (empty slot), do ADVANCE and leave out_valid at 0.
  - Otherwise set out_valid <= 1 and go to EMIT.
- EMIT:
  - out_valid held at 1; all out_* fields held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0, then ADVANCE.
- ADVANCE:
  - If cur_id == count_q-1: go to IDLE and pulse done next cycle.
  - Otherwise cur_id <= cur_id+1 and go to ISSUE.
- rd_id is always driven from cur_id and never changes while rd_busy = 1.
- Latency with an 8-word record reader (busy high 8 cycles):
  - Trigger at cycle T, busy high T+1..T+8, capture at T+9.
  - out_valid first seen high at T+10.
  - A start sampled at edge E gives out_valid after edge E+10.
  - Each skipped slot costs 10 cycles.
- Width rules:
  - cur_id compares against count_q-1 in NUMW bits.
  - count = 2^NUMW-1 is the largest legal value; there is no id wrap.
- out_ready asserted while out_valid = 0 has no effect.
- done and out_valid are never high in the same cycle.

Test Plan:
- Slots 0..2 hold ty=1,2,3 with x=10,20,30; count=3; out_ready tied 1 → three records with out_id 0,1,2 and matching fields. out_last=1 only on id 2; done pulses once after the third handshake; busy returns to 0.
- count=4 with slot 1 ty=0 → records emitted for ids 0, 2, 3 only; rd_trigger pulses exactly 4 times; done once.
- Backpressure: out_ready low for 5 cycles while out_valid=1 → fields and out_valid stable throughout, no new rd_trigger issued; the record is accepted on the first ready cycle.
- start with count=0 → no rd_trigger; done pulses one cycle later; busy stays 0.
- A second start pulse during a scan → ignored; the scan completes normally with a single done.
- rst asserted while in WAIT for slot 1 → outputs 0 asynchronously, no done. A new start afterwards rescans from id 0 correctly.
